// File: rtl/regfile_alu_pkg.sv
// Shared definitions for the register-file/ALU pipeline: opcodes, flag bit
// positions and default sizes.
package regfile_alu_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int NUM_REGS_DEF = 16;
   localparam int FLAGS_W      = 5;

   typedef enum logic [7:0] {
      OP_AND  = 8'h01,
      OP_OR   = 8'h02,
      OP_XOR  = 8'h03,
      OP_ADD  = 8'h05,
      OP_ADDC = 8'h07,
      OP_SUB  = 8'h09,
      OP_CMP  = 8'h0B,
      OP_MOV  = 8'h0D
   } alu_op_e;

   // Flag vector layout is {N,Z,F,L,C}.
   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

endpackage

// File: rtl/regfile_alu_pipe_if.sv
// Issue and writeback bundle between an instruction source and regfile_alu_pipe.
interface regfile_alu_pipe_if
   import regfile_alu_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
);
   localparam int SEL_W = $clog2(NUM_REGS);

   logic               in_valid;
   logic               in_ready;
   logic               stall;
   logic [7:0]         op;
   logic [SEL_W-1:0]   regA;
   logic [SEL_W-1:0]   regB;
   logic [SEL_W-1:0]   write_select;
   logic               reg_imm;
   logic [DATA_W-1:0]  immediate_value;
   logic               write_enable;
   logic               external_write_enable;
   logic [DATA_W-1:0]  external_write_value;
   logic               wb_valid;
   logic [SEL_W-1:0]   wb_select;
   logic [DATA_W-1:0]  wb_value;
   logic [FLAGS_W-1:0] flags;

   modport master (
      output in_valid, stall, op, regA, regB, write_select, reg_imm,
             immediate_value, write_enable, external_write_enable,
             external_write_value,
      input  in_ready, wb_valid, wb_select, wb_value, flags
   );

   modport slave (
      input  in_valid, stall, op, regA, regB, write_select, reg_imm,
             immediate_value, write_enable, external_write_enable,
             external_write_value,
      output in_ready, wb_valid, wb_select, wb_value, flags
   );

endinterface

// File: rtl/regfile_alu_pipe_alu.sv
// Purely combinational ALU: result plus candidate flags and a mask of which
// flags this opcode is allowed to change.
module alu_param
   import regfile_alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [7:0]         op_i,
   input  logic [DATA_W-1:0]  a_i,
   input  logic [DATA_W-1:0]  b_i,
   input  logic               carry_i,
   output logic [DATA_W-1:0]  result_o,
   output logic [FLAGS_W-1:0] flags_nxt_o,
   output logic [FLAGS_W-1:0] flags_mask_o
);

   localparam int MSB = DATA_W - 1;

   logic              cin;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;

   assign cin  = (op_i == OP_ADDC) ? carry_i : 1'b0;
   assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin};
   // Top bit of the widened difference is the unsigned borrow.
   assign diff = {1'b0, a_i} - {1'b0, b_i};

   always_comb begin
      // NOTE: every output gets a default first so no case path infers a latch.
      result_o     = '0;
      flags_nxt_o  = '0;
      flags_mask_o = '0;
      case (op_i)
         OP_ADD, OP_ADDC: begin
            result_o             = sum[MSB:0];
            flags_nxt_o[FLAG_C]  = sum[DATA_W];
            flags_nxt_o[FLAG_F]  = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            flags_mask_o[FLAG_C] = 1'b1;
            flags_mask_o[FLAG_F] = 1'b1;
         end
         OP_SUB: begin
            result_o             = diff[MSB:0];
            flags_nxt_o[FLAG_C]  = diff[DATA_W];
            flags_nxt_o[FLAG_F]  = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            flags_mask_o[FLAG_C] = 1'b1;
            flags_mask_o[FLAG_F] = 1'b1;
         end
         OP_CMP: begin
            result_o             = diff[MSB:0];
            flags_nxt_o[FLAG_Z]  = (a_i == b_i);
            flags_nxt_o[FLAG_L]  = (a_i < b_i);
            flags_nxt_o[FLAG_N]  = ($signed(a_i) < $signed(b_i));
            flags_mask_o[FLAG_Z] = 1'b1;
            flags_mask_o[FLAG_L] = 1'b1;
            flags_mask_o[FLAG_N] = 1'b1;
         end
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_MOV:  result_o = b_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Two-stage issue/writeback pipeline around a register file and ALU, with
// writeback-to-issue forwarding so dependent instructions never stall.
module regfile_alu_pipe
   import regfile_alu_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter bit ZERO_R0  = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   regfile_alu_pipe_if.slave  bus
);

   localparam int SEL_W = $clog2(NUM_REGS);

   logic [DATA_W-1:0]  regs_q [NUM_REGS];
   logic               wb_valid_q, wb_valid_d;
   logic [SEL_W-1:0]   wb_sel_q,   wb_sel_d;
   logic [DATA_W-1:0]  wb_val_q,   wb_val_d;
   logic [FLAGS_W-1:0] flags_q,    flags_d;

   logic [DATA_W-1:0]  op_a, op_b, alu_result;
   logic [FLAGS_W-1:0] alu_flags_nxt, alu_flags_mask;
   logic               dest_ok;

   assign bus.in_ready = ~bus.stall;

   // The pending writeback has not reached regs_q yet, so it must win.
   always_comb begin
      op_a = regs_q[bus.regA];
      if (wb_valid_q && (wb_sel_q == bus.regA)) op_a = wb_val_q;
      op_b = regs_q[bus.regB];
      if (wb_valid_q && (wb_sel_q == bus.regB)) op_b = wb_val_q;
      if (bus.reg_imm) op_b = bus.immediate_value;
   end

   alu_param #(.DATA_W(DATA_W)) u_alu (
      .op_i         (bus.op),
      .a_i          (op_a),
      .b_i          (op_b),
      .carry_i      (flags_q[FLAG_C]),
      .result_o     (alu_result),
      .flags_nxt_o  (alu_flags_nxt),
      .flags_mask_o (alu_flags_mask)
   );

   assign dest_ok = !(ZERO_R0 && (bus.write_select == '0));

   always_comb begin
      wb_valid_d = wb_valid_q;
      wb_sel_d   = wb_sel_q;
      wb_val_d   = wb_val_q;
      flags_d    = flags_q;
      if (!bus.stall) begin
         wb_valid_d = 1'b0;
         if (bus.in_valid) begin
            wb_valid_d = bus.write_enable && (bus.op != OP_CMP) && dest_ok;
            wb_sel_d   = bus.write_select;
            wb_val_d   = bus.external_write_enable ? bus.external_write_value : alu_result;
            if (!bus.external_write_enable)
               flags_d = (flags_q & ~alu_flags_mask) | (alu_flags_nxt & alu_flags_mask);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         wb_valid_q <= 1'b0;
         wb_sel_q   <= '0;
         wb_val_q   <= '0;
         flags_q    <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_sel_q   <= wb_sel_d;
         wb_val_q   <= wb_val_d;
         flags_q    <= flags_d;
      end
   end

   // A stalled writeback is held in the WB register and lands once stall drops.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the register file is reset on purpose: software relies on every register reading 0 after reset.
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wb_valid_q && !bus.stall) begin
         regs_q[wb_sel_q] <= wb_val_q;
      end
   end

   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_select = wb_sel_q;
   assign bus.wb_value  = wb_val_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Self-checking bench for regfile_alu_pipe: directed vector table, hand-written
// stall/reset sequences, and random instructions against a sequential ISA model.
module tb_regfile_alu_pipe;
   import regfile_alu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_alu_pipe_if #(.DATA_W(16), .NUM_REGS(16)) bus0 ();
   regfile_alu_pipe_if #(.DATA_W(32), .NUM_REGS(32)) bus1 ();

   regfile_alu_pipe #(.DATA_W(16), .NUM_REGS(16), .ZERO_R0(1'b0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0));
   regfile_alu_pipe #(.DATA_W(32), .NUM_REGS(32), .ZERO_R0(1'b1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [7:0]  op;
      int          ra, rb, ws;
      logic        ri;
      logic [15:0] imm;
      logic        we, ext;
      logic [15:0] ev;
      logic        xv;
      logic [15:0] xval;
      logic [4:0]  xfl;
   } vec_t;

   vec_t vtab[$];

   logic [7:0]  rnd_ops [10] = '{OP_ADD, OP_ADDC, OP_SUB, OP_CMP, OP_AND,
                                 OP_OR, OP_XOR, OP_MOV, 8'h00, 8'hFF};
   logic [15:0] mregs [16];
   logic [4:0]  mflags;

   function automatic vec_t mk(input logic [7:0] op, input int ra, input int rb, input int ws,
                               input logic ri, input logic [15:0] imm, input logic we,
                               input logic ext, input logic [15:0] ev, input logic xv,
                               input logic [15:0] xval, input logic [4:0] xfl);
      vec_t v;
      v.op = op; v.ra = ra; v.rb = rb; v.ws = ws; v.ri = ri; v.imm = imm;
      v.we = we; v.ext = ext; v.ev = ev; v.xv = xv; v.xval = xval; v.xfl = xfl;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus0.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
   endtask

   task automatic set_in(input int d, input logic [7:0] op, input int ra, input int rb,
                         input int ws, input logic ri, input logic [31:0] imm,
                         input logic we, input logic ext, input logic [31:0] ev);
      if (d == 0) begin
         bus0.in_valid = 1'b1; bus0.op = op;
         bus0.regA = 4'(ra); bus0.regB = 4'(rb); bus0.write_select = 4'(ws);
         bus0.reg_imm = ri; bus0.immediate_value = imm[15:0];
         bus0.write_enable = we; bus0.external_write_enable = ext;
         bus0.external_write_value = ev[15:0];
      end else begin
         bus1.in_valid = 1'b1; bus1.op = op;
         bus1.regA = 5'(ra); bus1.regB = 5'(rb); bus1.write_select = 5'(ws);
         bus1.reg_imm = ri; bus1.immediate_value = imm;
         bus1.write_enable = we; bus1.external_write_enable = ext;
         bus1.external_write_value = ev;
      end
   endtask

   function automatic logic o_v(input int d);
      return (d == 0) ? bus0.wb_valid : bus1.wb_valid;
   endfunction
   function automatic logic [31:0] o_val(input int d);
      return (d == 0) ? {16'h0, bus0.wb_value} : bus1.wb_value;
   endfunction
   function automatic logic [31:0] o_sel(input int d);
      return (d == 0) ? {28'h0, bus0.wb_select} : {27'h0, bus1.wb_select};
   endfunction
   function automatic logic [4:0] o_fl(input int d);
      return (d == 0) ? bus0.flags : bus1.flags;
   endfunction

   task automatic expect_wb(input string name, input int d, input logic xv,
                            input logic [31:0] xval, input int xsel, input logic [4:0] xfl);
      check({name, " wb_valid"}, {31'h0, o_v(d)}, {31'h0, xv});
      if (xv) begin
         check({name, " wb_value"}, o_val(d), xval);
         check({name, " wb_select"}, o_sel(d), xsel);
      end
      check({name, " flags"}, {27'h0, o_fl(d)}, {27'h0, xfl});
   endtask

   // Sequential ISA semantics, computed with plain integer arithmetic.
   function automatic logic [15:0] model_exec(input logic [7:0] op, input logic [15:0] a,
                                              input logic [15:0] b, inout logic [4:0] fl);
      int ua, ub, sa, sb, s, ss, cin;
      ua = int'(a);          ub = int'(b);
      sa = int'(signed'(a)); sb = int'(signed'(b));
      case (op)
         OP_ADD, OP_ADDC: begin
            cin = (op == OP_ADDC) ? int'(fl[FLAG_C]) : 0;
            s = ua + ub + cin; ss = sa + sb + cin;
            fl[FLAG_C] = (s > 65535);
            fl[FLAG_F] = (ss > 32767) || (ss < -32768);
            return 16'(s);
         end
         OP_SUB: begin
            s = ua - ub; ss = sa - sb;
            fl[FLAG_C] = (ua < ub);
            fl[FLAG_F] = (ss > 32767) || (ss < -32768);
            return 16'(s);
         end
         OP_CMP: begin
            fl[FLAG_Z] = (ua == ub);
            fl[FLAG_L] = (ua < ub);
            fl[FLAG_N] = (sa < sb);
            return 16'h0;
         end
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_MOV:  return b;
         default: return 16'h0;
      endcase
   endfunction

   task automatic run_random(input int n);
      int          kind, ra, rb, ws, k;
      logic [7:0]  op;
      logic        ri, we, ext, xv;
      logic [15:0] imm, ev, a, b, res, xval;
      logic [4:0]  fl;
      xv = 1'b0; xval = '0;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mflags = '0;
      for (int it = 0; it < n; it++) begin
         kind = int'($urandom_range(0, 9));
         op   = rnd_ops[$urandom_range(0, 9)];
         ra   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
         rb   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
         ws   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
         ri   = ($urandom_range(0, 3) == 0);
         we   = ($urandom_range(0, 7) != 0);
         ext  = ($urandom_range(0, 7) == 0);
         imm  = 16'($urandom);
         ev   = 16'($urandom);
         if (kind == 0) begin
            idle();
            tick();
            xv = 1'b0;
            check("rand idle wb_valid", {31'h0, bus0.wb_valid}, 32'h0);
            check("rand idle flags", {27'h0, bus0.flags}, {27'h0, mflags});
         end else begin
            if (kind == 1) begin
               bus0.stall = 1'b1;
               set_in(0, op, ra, rb, ws, ri, {16'h0, imm}, we, ext, {16'h0, ev});
               k = int'($urandom_range(1, 3));
               repeat (k) begin
                  tick();
                  check("rand stall in_ready", {31'h0, bus0.in_ready}, 32'h0);
                  expect_wb("rand stall hold", 0, xv, {16'h0, xval}, int'(bus0.wb_select), mflags);
               end
               bus0.stall = 1'b0;
            end
            set_in(0, op, ra, rb, ws, ri, {16'h0, imm}, we, ext, {16'h0, ev});
            tick();
            a  = mregs[ra];
            b  = ri ? imm : mregs[rb];
            fl = mflags;
            res = model_exec(op, a, b, fl);
            if (!ext) mflags = fl;
            xv   = we && (op != OP_CMP);
            xval = ext ? ev : res;
            if (xv) mregs[ws] = xval;
            expect_wb("rand issue", 0, xv, {16'h0, xval}, ws, mflags);
            check("rand in_ready", {31'h0, bus0.in_ready}, 32'h1);
         end
      end
      idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      bus0.stall = 1'b0;
      bus1.stall = 1'b0;
      set_in(0, 8'h00, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      set_in(1, 8'h00, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      idle();

      // Directed vectors (16-bit, r0 is an ordinary register that stays 0).
      vtab.push_back(mk(OP_MOV,  0, 0,  1, 1, 16'h0007, 1, 0, 16'h0,    1, 16'h0007, 5'b00000));
      vtab.push_back(mk(OP_ADD,  1, 1,  2, 0, 16'h0000, 1, 0, 16'h0,    1, 16'h000E, 5'b00000));
      vtab.push_back(mk(OP_MOV,  0, 0,  6, 1, 16'hFFFF, 1, 0, 16'h0,    1, 16'hFFFF, 5'b00000));
      vtab.push_back(mk(OP_ADD,  6, 0,  7, 1, 16'h0001, 1, 0, 16'h0,    1, 16'h0000, 5'b00001));
      vtab.push_back(mk(OP_ADDC, 0, 0,  8, 1, 16'h0000, 1, 0, 16'h0,    1, 16'h0001, 5'b00000));
      vtab.push_back(mk(OP_MOV,  0, 0,  3, 1, 16'h0005, 1, 0, 16'h0,    1, 16'h0005, 5'b00000));
      vtab.push_back(mk(OP_MOV,  0, 0,  4, 1, 16'hFFFB, 1, 0, 16'h0,    1, 16'hFFFB, 5'b00000));
      vtab.push_back(mk(OP_CMP,  3, 4,  3, 0, 16'h0000, 1, 0, 16'h0,    0, 16'h0000, 5'b00010));
      vtab.push_back(mk(OP_OR,   3, 0,  9, 1, 16'h0000, 1, 0, 16'h0,    1, 16'h0005, 5'b00010));
      vtab.push_back(mk(OP_OR,   4, 0,  9, 1, 16'h0000, 1, 0, 16'h0,    1, 16'hFFFB, 5'b00010));
      vtab.push_back(mk(OP_SUB,  3, 4, 10, 0, 16'h0000, 1, 0, 16'h0,    1, 16'h000A, 5'b00011));
      vtab.push_back(mk(OP_XOR,  4, 3, 11, 0, 16'h0000, 1, 0, 16'h0,    1, 16'hFFFE, 5'b00011));
      vtab.push_back(mk(OP_AND,  4, 0, 12, 1, 16'h00F0, 1, 0, 16'h0,    1, 16'h00F0, 5'b00011));
      vtab.push_back(mk(8'h04,   3, 4, 13, 0, 16'h0000, 1, 0, 16'h0,    1, 16'h0000, 5'b00011));
      vtab.push_back(mk(OP_ADD,  3, 3, 14, 0, 16'h0000, 1, 1, 16'hBEEF, 1, 16'hBEEF, 5'b00011));
      vtab.push_back(mk(OP_MOV,  0, 0,  5, 1, 16'h7FFF, 1, 0, 16'h0,    1, 16'h7FFF, 5'b00011));
      vtab.push_back(mk(OP_ADD,  5, 0,  5, 1, 16'h0001, 1, 0, 16'h0,    1, 16'h8000, 5'b00110));
      vtab.push_back(mk(OP_MOV,  0, 0,  1, 1, 16'h1234, 0, 0, 16'h0,    0, 16'h0000, 5'b00110));
      vtab.push_back(mk(OP_OR,   1, 0,  2, 1, 16'h0000, 1, 0, 16'h0,    1, 16'h0007, 5'b00110));
      vtab.push_back(mk(OP_SUB,  0, 0, 15, 1, 16'h0001, 1, 0, 16'h0,    1, 16'hFFFF, 5'b00011));
      vtab.push_back(mk(OP_CMP,  3, 0,  0, 1, 16'h0005, 1, 0, 16'h0,    0, 16'h0000, 5'b01001));
      vtab.push_back(mk(OP_CMP,  4, 0,  0, 1, 16'h0005, 1, 0, 16'h0,    0, 16'h0000, 5'b10001));
      vtab.push_back(mk(OP_ADD, 15, 15, 15, 0, 16'h0000, 1, 0, 16'h0,   1, 16'hFFFE, 5'b10001));
      vtab.push_back(mk(OP_ADDC, 15, 0, 14, 0, 16'h0000, 1, 0, 16'h0,   1, 16'hFFFF, 5'b10000));

      // Reset state.
      tick();
      expect_wb("in reset dut0", 0, 1'b0, 32'h0, 0, 5'b0);
      check("in reset wb_value", o_val(0), 32'h0);
      check("in reset wb_select", o_sel(0), 32'h0);
      check("in reset in_ready", {31'h0, bus0.in_ready}, 32'h1);
      reset = 1'b0;
      tick();
      expect_wb("after reset dut0", 0, 1'b0, 32'h0, 0, 5'b0);
      expect_wb("after reset dut1", 1, 1'b0, 32'h0, 0, 5'b0);
      for (int r = 0; r < 16; r++) begin
         set_in(0, OP_OR, r, 0, r, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
         tick();
         check($sformatf("reset read r%0d", r), o_val(0), 32'h0);
      end
      for (int r = 0; r < 32; r++) begin
         set_in(1, OP_OR, r, 0, r, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
         tick();
         check($sformatf("reset read32 r%0d", r), o_val(1), 32'h0);
      end
      idle();
      tick();

      // Back-to-back table: every vector issues in consecutive cycles.
      foreach (vtab[i]) begin
         set_in(0, vtab[i].op, vtab[i].ra, vtab[i].rb, vtab[i].ws, vtab[i].ri,
                {16'h0, vtab[i].imm}, vtab[i].we, vtab[i].ext, {16'h0, vtab[i].ev});
         tick();
         expect_wb($sformatf("vec%0d", i), 0, vtab[i].xv, {16'h0, vtab[i].xval}, vtab[i].ws, vtab[i].xfl);
      end

      // Stall holds a pending write until stall falls.
      set_in(0, OP_MOV, 0, 0, 13, 1'b1, 32'h9, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("stall mov", 0, 1'b1, 32'h9, 13, 5'b10000);
      check("stall r13 not yet written", {16'h0, dut0.regs_q[13]}, 32'h0);
      bus0.stall = 1'b1;
      set_in(0, OP_OR, 13, 0, 10, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("stall%0d in_ready", c), {31'h0, bus0.in_ready}, 32'h0);
         expect_wb($sformatf("stall%0d hold", c), 0, 1'b1, 32'h9, 13, 5'b10000);
         check($sformatf("stall%0d r13 held", c), {16'h0, dut0.regs_q[13]}, 32'h0);
      end
      bus0.stall = 1'b0;
      tick();
      expect_wb("stall release fwd", 0, 1'b1, 32'h9, 10, 5'b10000);
      check("stall release r13 written", {16'h0, dut0.regs_q[13]}, 32'h9);
      idle();
      tick();
      check("idle clears wb_valid", {31'h0, bus0.wb_valid}, 32'h0);
      set_in(0, OP_OR, 13, 0, 11, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("regfile read r13", 0, 1'b1, 32'h9, 11, 5'b10000);

      // Reset while a write is in flight.
      set_in(0, OP_MOV, 0, 0, 6, 1'b1, 32'h55, 1'b1, 1'b0, 32'h0);
      tick();
      check("inflight wb_valid", {31'h0, bus0.wb_valid}, 32'h1);
      idle();
      reset = 1'b1;
      #1;
      expect_wb("async reset", 0, 1'b0, 32'h0, 0, 5'b0);
      check("async reset wb_value", o_val(0), 32'h0);
      check("reset in_ready", {31'h0, bus0.in_ready}, 32'h1);
      bus0.stall = 1'b1;
      #1;
      check("reset stall in_ready", {31'h0, bus0.in_ready}, 32'h0);
      bus0.stall = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_in(0, OP_OR, 6, 0, 7, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("inflight discarded r6", 0, 1'b1, 32'h0, 7, 5'b0);
      idle();
      tick();

      run_random(300);
      tick();

      // Wide configuration with hard-wired r0.
      set_in(1, OP_MOV, 0, 0, 0, 1'b1, 32'd5, 1'b1, 1'b0, 32'h0);
      tick();
      check("r0 write suppressed", {31'h0, bus1.wb_valid}, 32'h0);
      set_in(1, OP_OR, 0, 0, 1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("r0 reads zero", 1, 1'b1, 32'h0, 1, 5'b00000);
      set_in(1, OP_MOV, 0, 0, 2, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("mov32", 1, 1'b1, 32'hFFFF_FFFF, 2, 5'b00000);
      set_in(1, OP_ADD, 2, 0, 3, 1'b1, 32'h1, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("add32 carry", 1, 1'b1, 32'h0, 3, 5'b00001);
      set_in(1, OP_ADDC, 0, 0, 4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("addc32", 1, 1'b1, 32'h1, 4, 5'b00000);
      set_in(1, OP_MOV, 0, 0, 5, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("mov32 min", 1, 1'b1, 32'h8000_0000, 5, 5'b00000);
      set_in(1, OP_ADD, 5, 5, 6, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("add32 overflow", 1, 1'b1, 32'h0, 6, 5'b00101);
      set_in(1, OP_SUB, 0, 0, 7, 1'b1, 32'h1, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("sub32 borrow", 1, 1'b1, 32'hFFFF_FFFF, 7, 5'b00001);
      set_in(1, OP_MOV, 0, 0, 8, 1'b1, 32'h1, 1'b1, 1'b0, 32'h0);
      tick();
      check("inflight32 wb_valid", {31'h0, bus1.wb_valid}, 32'h1);
      idle();
      reset = 1'b1;
      #1;
      expect_wb("async reset32", 1, 1'b0, 32'h0, 0, 5'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_in(1, OP_OR, 8, 0, 9, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      expect_wb("inflight32 discarded r8", 1, 1'b1, 32'h0, 9, 5'b0);
      idle();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_alu_pipe.md
REGFILE_ALU_PIPE -- requirements
Module: regfile_alu_pipe

Interface
REQ-001 Parameter DATA_W, default 16: datapath, register and immediate width.
REQ-002 Parameter NUM_REGS, default 16: register count; SEL_W = clog2(NUM_REGS) is derived.
REQ-003 Parameter ZERO_R0, default 0: when 1, register 0 reads as 0 and ignores writes.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1: asynchronous, active-high reset.
REQ-006 Port in_valid  in  1: instruction present on the issue inputs.
REQ-007 Port in_ready  out  1: block accepts the instruction this cycle; equals !stall.
REQ-008 Port stall  in  1: freeze request.
REQ-009 Port op  in  8: ALU opcode.
REQ-010 Ports regA, regB, write_select  in  SEL_W each: source A, source B and destination register selects.
REQ-011 Port reg_imm  in  1: 1 selects immediate_value as operand B.
REQ-012 Port immediate_value  in  DATA_W: immediate operand.
REQ-013 Port write_enable  in  1: instruction writes its destination register.
REQ-014 Port external_write_enable  in  1: write external_write_value instead of the ALU result.
REQ-015 Port external_write_value  in  DATA_W: external writeback value.
REQ-016 Port wb_valid  out  1: a write occurs at the next edge.
REQ-017 Port wb_select  out  SEL_W: register written at the next edge.
REQ-018 Port wb_value  out  DATA_W: value written at the next edge.
REQ-019 Port flags  out  5: architectural flags {N,Z,F,L,C}, bits [4:0].

Function
REQ-020 The block SHALL be a two-stage pipeline.
- Issue: on accept (in_valid & in_ready), operands SHALL be read with forwarding, the ALU SHALL evaluate combinationally, and result, write_select and write flag SHALL be latched into the WB register.
- Writeback: the next edge SHALL write the latched result to the regfile.
REQ-021 Opcodes SHALL be ADD 8'h05, ADDC 8'h07, SUB 8'h09, CMP 8'h0B, AND 8'h01, OR 8'h02, XOR 8'h03, MOV 8'h0D (MOV result = B); any other opcode SHALL give result 0 and leave flags unchanged.
REQ-022 All arithmetic SHALL be modulo 2^DATA_W; ADDC SHALL add flags[0] as carry-in.
REQ-023 ADD, ADDC and SUB SHALL update C (unsigned carry-out; borrow for SUB) and F (signed overflow) only.
REQ-024 CMP SHALL update Z (A==B), L (A<B unsigned) and N (A<B signed) only, and SHALL suppress writeback.
REQ-025 Logic ops and MOV SHALL leave flags unchanged; flags SHALL load on the accept edge, so a back-to-back ADDC sees the preceding ADD's carry.
REQ-026 When external_write_enable=1, the WB value SHALL be external_write_value, and flags SHALL NOT update.
REQ-027 wb_valid SHALL be 1 when the WB register holds an accepted instruction with write_enable=1 that is not CMP (and not register 0 when ZERO_R0=1).
REQ-028 Forwarding SHALL be as follows.
- If wb_valid and wb_select equals regA (or regB), the operand SHALL be wb_value.
- Otherwise the operand SHALL be the regfile output.
- An immediate overrides B regardless.
REQ-029 A cycle with no accept SHALL clear WB-register validity at the next edge.
REQ-030 While stall=1, nothing SHALL be accepted, the WB register, regfile and flags SHALL hold, and the pending write SHALL complete on the first edge after stall falls.
REQ-031 A write and a read of the same register in one cycle SHALL return the new value, through forwarding.

Reset
REQ-032 Assertion of reset SHALL immediately clear all registers, flags and the WB register: wb_valid=0, wb_select=0, wb_value=0, flags=5'b0.
REQ-033 An in-flight writeback SHALL be discarded when reset asserts, and in_ready SHALL follow !stall during reset.

Structure
REQ-034 Opcode constants, flag bit indices and the default DATA_W and NUM_REGS SHALL live in a shared package, regfile_alu_pkg.
REQ-035 The ALU SHALL be one sub-module, alu_param, parameterised by DATA_W, which is purely combinational and outputs result and a 5-bit flags-next value with an update mask.

Verification
REQ-036 After reset, with no issue: wb_valid=0, flags=0, and every register reads 0.
REQ-037 Back-to-back MOV r1,#7 ; ADD r2=r1+r1 -> r2=14, with r1 forwarded and no stall cycle.
REQ-038 With DATA_W=16: ADD 16'hFFFF+16'h0001 -> result 0, C=1; then ADDC 0+0 -> result 1, C=0.
REQ-039 CMP r3=5 vs r4=16'hFFFB -> L=1, N=0, Z=0, with registers unchanged.
REQ-040 Issue MOV r5,#9, then raise stall for 3 cycles -> r5 is written only after stall falls, and in_ready=0 throughout the stall.
REQ-041 Reset asserted while wb_valid=1 -> target register stays 0; repeat with DATA_W=32, NUM_REGS=32, ZERO_R0=1 -> a write to r0 is ignored and 32-bit carry is correct.
